tick_counter: RTL

- Parametrised prescaled event counter for display and timing paths, e.g. driving seven-segment digit values at a human-visible rate.
- A free-running prescaler divides the system clock into a periodic step strobe.
- A WIDTH-bit counter steps on each strobe, either up or down, with programmable modulo, wrap/saturate mode, synchronous clear and parallel load.
- Emits a tick pulse per step period and a wrap pulse on roll-over.

---
 rtl/tick_counter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : tick_counter
// Desc     : Prescaled up/down event counter with programmable modulo,
//            wrap/saturate limit handling, synchronous clear and parallel load.
//            Define TICK_COUNTER_BCD_EN to count in packed BCD (WIDTH/4 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tick_counter #(
    parameter int              PRESCALE = 100000000,
    parameter int              WIDTH    = 32,
    parameter longint unsigned MODULO   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             up_down,
    input  logic             saturate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             at_limit
);

    localparam int                c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

    generate
        if (PRESCALE < 1) begin : g_chk_prescale
            $error("tick_counter: PRESCALE must be >= 1");
        end
        if (WIDTH < 1) begin : g_chk_width
            $error("tick_counter: WIDTH must be >= 1");
        end
    endgenerate

    logic [c_PS_W-1:0] r_prescale;
    logic [WIDTH-1:0]  r_count;
    logic              r_tick;
    logic              r_wrap;

    logic              w_term;
    logic              w_step;
    logic              w_at_max;
    logic              w_at_zero;
    logic              w_roll;
    logic [WIDTH-1:0]  w_inc;
    logic [WIDTH-1:0]  w_dec;
    logic [WIDTH-1:0]  w_load_val;
    logic [WIDTH-1:0]  w_count_next;

`ifdef TICK_COUNTER_BCD_EN
    localparam int               c_DIGITS = WIDTH / 4;
    localparam logic [WIDTH-1:0] c_MAX    = WIDTH'({c_DIGITS{4'h9}});

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_chk_bcd
            $error("tick_counter: BCD build needs WIDTH as a non-zero multiple of 4");
        end
    endgenerate

    // Ripple carry through the digits; only used below MAX so no carry-out.
    function automatic logic [WIDTH-1:0] f_bcd_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < c_DIGITS; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_bcd_dec(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = 0; d < c_DIGITS; d++) begin
            if (borrow) begin
                if (v[d*4 +: 4] == 4'd0) begin
                    r[d*4 +: 4] = 4'd9;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_bcd_clamp(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        for (int d = 0; d < c_DIGITS; d++) begin
            if (v[d*4 +: 4] > 4'd9) begin
                r[d*4 +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    assign w_inc      = f_bcd_inc(r_count);
    assign w_dec      = f_bcd_dec(r_count);
    assign w_load_val = f_bcd_clamp(load_value);
`else
    // MODULO of 2^WIDTH truncates to all ones, identical to full range.
    localparam logic [WIDTH-1:0] c_MAX = (MODULO == 0) ? {WIDTH{1'b1}}
                                                        : WIDTH'(MODULO - 64'd1);

    generate
        if ((WIDTH < 64) && (MODULO > (64'd1 << WIDTH))) begin : g_chk_modulo
            $error("tick_counter: MODULO must not exceed 2^WIDTH");
        end
    endgenerate

    assign w_inc      = r_count + WIDTH'(1);
    assign w_dec      = r_count - WIDTH'(1);
    assign w_load_val = (load_value > c_MAX) ? c_MAX : load_value;
`endif

    assign w_term    = (r_prescale == c_PS_LAST);
    assign w_step    = enable && w_term && !load;
    assign w_at_max  = (r_count == c_MAX);
    assign w_at_zero = (r_count == '0);

    always_comb begin
        w_count_next = r_count;
        w_roll       = 1'b0;
        if (up_down) begin
            if (!w_at_max) begin
                w_count_next = w_inc;
            end else if (!saturate) begin
                w_count_next = '0;
                w_roll       = 1'b1;
            end
        end else begin
            if (!w_at_zero) begin
                w_count_next = w_dec;
            end else if (!saturate) begin
                w_count_next = c_MAX;
                w_roll       = 1'b1;
            end
        end
    end

    // Prescaler free-runs regardless of enable/load/mode inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
        end else if (clear) begin
            r_prescale <= '0;
        end else if (w_term) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + c_PS_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_load_val;
        end else if (w_step) begin
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (clear) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_term;
            r_wrap <= w_step && w_roll;
        end
    end

    assign count    = r_count;
    assign tick     = r_tick;
    assign wrap     = r_wrap;
    assign at_limit = up_down ? w_at_max : w_at_zero;

endmodule
`default_nettype wire
